l1_dcache: RTL

Direct-mapped, write-back, write-allocate L1 data cache that sits directly downstream of the pipeline's MEM stage, consuming its `D_mem_*` request port and driving the 128-bit physical-memory port. Hits complete combinationally in the request cycle, so the pipeline stall logic (stall while request is active and `mem_resp` is low) sees no extra latency. Misses run a writeback/fill state machine against physical memory.

---
 rtl/l1_dcache.sv | 132 +++++++++++++
 1 files changed

// File: rtl/l1_dcache.sv
`default_nettype none
// ----------------------------------------------------------------------------
// l1_dcache : direct-mapped, write-back, write-allocate L1 data cache with
//             same-cycle hits and a writeback/fill miss engine (128-bit lines)
// Revision  : 1.0
// ----------------------------------------------------------------------------
module l1_dcache #(
  parameter int INDEX_BITS = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int c_NUM_SETS = 1 << INDEX_BITS;
  localparam int c_TAG_BITS = 12 - INDEX_BITS;

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_WRITEBACK = 2'd1;
  localparam logic [1:0] c_FILL      = 2'd2;

  logic [1:0]            r_state;
  logic [c_NUM_SETS-1:0] r_valid;
  logic [c_NUM_SETS-1:0] r_dirty;
  logic [c_TAG_BITS-1:0] r_tag  [c_NUM_SETS];
  logic [127:0]          r_data [c_NUM_SETS];

  // Miss address is latched so the memory transaction survives a dropped request
  logic [c_TAG_BITS-1:0] r_miss_tag;
  logic [INDEX_BITS-1:0] r_miss_index;

  logic [c_TAG_BITS-1:0] w_req_tag;
  logic [INDEX_BITS-1:0] w_req_index;
  logic [2:0]            w_offset;
  logic                  w_request;
  logic                  w_idle;
  logic                  w_hit;
  logic                  w_write_hit;
  logic [127:0]          w_line;
  logic [15:0]           w_word;
  logic [15:0]           w_merged_word;
  logic                  w_unused;

  assign w_req_tag   = mem_address[15:4+INDEX_BITS];
  assign w_req_index = mem_address[3+INDEX_BITS:4];
  assign w_offset    = mem_address[3:1];
  assign w_unused    = &{1'b0, mem_address[0]};

  assign w_request   = mem_read | mem_write;
  assign w_idle      = (r_state == c_IDLE);
  assign w_hit       = r_valid[w_req_index] && (r_tag[w_req_index] == w_req_tag);
  assign w_line      = r_data[w_req_index];
  assign w_word      = w_line[{w_offset, 4'b0000} +: 16];

  assign mem_resp    = w_idle & w_request & w_hit;
  assign mem_rdata   = (w_idle & w_hit) ? w_word : 16'h0000;
  assign w_write_hit = mem_resp & mem_write;

  assign w_merged_word = {mem_byte_enable[1] ? mem_wdata[15:8] : w_word[15:8],
                          mem_byte_enable[0] ? mem_wdata[7:0]  : w_word[7:0]};

  // Memory-side outputs decode only registered state and the latched miss set
  assign pmem_read    = (r_state == c_FILL);
  assign pmem_write   = (r_state == c_WRITEBACK);
  assign pmem_wdata   = r_data[r_miss_index];

  always_comb begin
    pmem_address = 16'h0000;
    if (r_state == c_FILL)
      pmem_address = {r_miss_tag, r_miss_index, 4'b0000};
    else if (r_state == c_WRITEBACK)
      pmem_address = {r_tag[r_miss_index], r_miss_index, 4'b0000};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= c_IDLE;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_miss_tag   <= '0;
      r_miss_index <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_request && !w_hit) begin
            r_miss_tag   <= w_req_tag;
            r_miss_index <= w_req_index;
            r_state      <= (r_valid[w_req_index] && r_dirty[w_req_index]) ? c_WRITEBACK : c_FILL;
          end
          if (w_write_hit && (mem_byte_enable != 2'b00))
            r_dirty[w_req_index] <= 1'b1;
        end
        c_WRITEBACK: begin
          if (pmem_resp)
            r_state <= c_FILL;
        end
        c_FILL: begin
          if (pmem_resp) begin
            r_valid[r_miss_index] <= 1'b1;
            r_dirty[r_miss_index] <= 1'b0;
            r_state               <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify their contents
  always_ff @(posedge clk) begin
    if (w_write_hit)
      r_data[w_req_index][{w_offset, 4'b0000} +: 16] <= w_merged_word;
    if ((r_state == c_FILL) && pmem_resp) begin
      r_data[r_miss_index] <= pmem_rdata;
      r_tag[r_miss_index]  <= r_miss_tag;
    end
  end

endmodule
`default_nettype wire
